oflow_fe_multi: RTL

OFLOW_FE_MULTI -- requirements
Module: oflow_fe_multi

---
 rtl/oflow_fe_multi_if.sv | 39 +++
 rtl/oflow_fe_multi.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/oflow_fe_multi_if.sv
// Beat-level handshake and data bus for the multi-lane bbox front end.
// The slave view belongs to the block; the master view belongs to whatever feeds and drains it.
interface oflow_fe_multi_if #(
  parameter int NUM_LANES = 4,
  parameter int COORD_W   = 11,
  parameter int DIM_W     = 8,
  parameter int COLOR_W   = 24
);
  localparam int BBOX_W = 2*COORD_W + 2*DIM_W + 2*COLOR_W;

  logic                            in_valid;
  logic                            in_ready;
  logic                            frame_end;
  logic [NUM_LANES*BBOX_W-1:0]     bbox_in;
  logic [NUM_LANES-1:0]            lane_en;

  logic                            out_valid;
  logic                            out_ready;
  logic [NUM_LANES*4*COORD_W-1:0]  position_concate;
  logic [NUM_LANES*2*COORD_W-1:0]  cm_concate;
  logic [NUM_LANES*DIM_W-1:0]      width;
  logic [NUM_LANES*DIM_W-1:0]      height;
  logic [NUM_LANES*COLOR_W-1:0]    color1;
  logic [NUM_LANES*COLOR_W-1:0]    color2;
  logic [NUM_LANES-1:0]            lane_valid;
  logic [NUM_LANES-1:0]            sat_flag;

  modport slave (
    input  in_valid, frame_end, bbox_in, lane_en, out_ready,
    output in_ready, out_valid, position_concate, cm_concate, width, height,
           color1, color2, lane_valid, sat_flag
  );

  modport master (
    output in_valid, frame_end, bbox_in, lane_en, out_ready,
    input  in_ready, out_valid, position_concate, cm_concate, width, height,
           color1, color2, lane_valid, sat_flag
  );
endinterface

// File: rtl/oflow_fe_multi.sv
// Multi-lane bbox front end: corner/centre computation with clipping, two-stage
// pipeline into an output FIFO, framed by a small start/drain/done FSM.
module oflow_fe_lane #(
  parameter  int COORD_W = 11,
  parameter  int DIM_W   = 8,
  parameter  int COLOR_W = 24,
  localparam int BBOX_W  = 2*COORD_W + 2*DIM_W + 2*COLOR_W,
  localparam int RES_W   = 6*COORD_W + 2*DIM_W + 2*COLOR_W + 2
) (
  input  logic [BBOX_W-1:0] bbox,
  input  logic              en,
  output logic [RES_W-1:0]  res
);
  logic [COORD_W-1:0] x_tl, y_tl, x_br, y_br, x_cm, y_cm;
  logic [DIM_W-1:0]   w, h;
  logic [COLOR_W-1:0] c1, c2;
  logic [COORD_W:0]   x_sum, y_sum;

  assign {x_tl, y_tl, w, h, c1, c2} = bbox;
  assign x_sum = {1'b0, x_tl} + (COORD_W+1)'(w);
  assign y_sum = {1'b0, y_tl} + (COORD_W+1)'(h);
  // Carry out of the coordinate range means the corner fell off the frame: clip.
  assign x_br  = x_sum[COORD_W] ? '1 : x_sum[COORD_W-1:0];
  assign y_br  = y_sum[COORD_W] ? '1 : y_sum[COORD_W-1:0];
  assign x_cm  = COORD_W'(({1'b0, x_tl} + {1'b0, x_br}) >> 1);
  assign y_cm  = COORD_W'(({1'b0, y_tl} + {1'b0, y_br}) >> 1);

  assign res = en ? {x_tl, y_tl, x_br, y_br, x_cm, y_cm, w, h, c1, c2, 1'b1,
                     x_sum[COORD_W] | y_sum[COORD_W]} : '0;
endmodule

module oflow_fe_multi #(
  parameter int NUM_LANES  = 4,
  parameter int COORD_W    = 11,
  parameter int DIM_W      = 8,
  parameter int COLOR_W    = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_N,
  input  logic                 start_fe,
  output logic                 done_fe,
  output logic [15:0]          obj_count,
  oflow_fe_multi_if.slave      bus
);
  localparam int BBOX_W = 2*COORD_W + 2*DIM_W + 2*COLOR_W;
  localparam int RES_W  = 6*COORD_W + 2*DIM_W + 2*COLOR_W + 2;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int PCW    = $clog2(NUM_LANES + 1);
  localparam int STAGES = 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;

  logic [STAGES:0]                    vld_pipe;
  logic [STAGES:1]                    vld_q;
  logic [NUM_LANES-1:0][BBOX_W-1:0]   s1_bbox;
  logic [NUM_LANES-1:0]               s1_en;
  logic [NUM_LANES-1:0][RES_W-1:0]    s2_res, head;
  logic [NUM_LANES-1:0][RES_W-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]                      wptr, rptr;
  logic [AW:0]                        count, count_nxt, occ;
  logic                               accept, push, pop;
  logic [PCW-1:0]                     pc;
  logic [16:0]                        cnt_sum;

  // Beats in S1 are already committed to a FIFO slot, so they count against space.
  assign occ          = count + (AW+1)'(vld_q[1]);
  assign bus.in_ready = (state == RUN) && (occ < DEPTH_C);
  assign accept       = bus.in_valid && bus.in_ready;
  assign vld_pipe     = {vld_q, accept};
  assign push         = vld_pipe[STAGES];
  assign bus.out_valid = (count != '0);
  assign pop          = bus.out_valid && bus.out_ready;
  assign count_nxt    = count + (AW+1)'(push) - (AW+1)'(pop);

  always_comb begin
    pc = '0;
    for (int i = 0; i < NUM_LANES; i++) pc = pc + PCW'(bus.lane_en[i]);
  end
  assign cnt_sum = {1'b0, obj_count} + 17'(pc);

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state     <= IDLE;
      done_fe   <= 1'b0;
      obj_count <= '0;
    end else begin
      done_fe <= 1'b0;
      case (state)
        IDLE: if (start_fe) begin
          state     <= RUN;
          obj_count <= '0;
        end
        RUN: begin
          if (accept) obj_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
          if (accept && bus.frame_end) state <= DRAIN;
        end
        // Leave as the last beat pops so done_fe lands the cycle after it.
        DRAIN: if (!vld_q[1] && count_nxt == '0) begin
          state   <= DONE;
          done_fe <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      vld_q <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      count <= count_nxt;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_bbox <= bus.bbox_in;
      s1_en   <= bus.lane_en;
    end
    if (push) mem[wptr] <= s2_res;
  end

  assign head = bus.out_valid ? mem[rptr] : '0;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    oflow_fe_lane #(.COORD_W(COORD_W), .DIM_W(DIM_W), .COLOR_W(COLOR_W)) u_lane (
      .bbox (s1_bbox[i]),
      .en   (s1_en[i]),
      .res  (s2_res[i])
    );
    assign {bus.position_concate[i*4*COORD_W +: 4*COORD_W],
            bus.cm_concate[i*2*COORD_W +: 2*COORD_W],
            bus.width[i*DIM_W +: DIM_W], bus.height[i*DIM_W +: DIM_W],
            bus.color1[i*COLOR_W +: COLOR_W], bus.color2[i*COLOR_W +: COLOR_W],
            bus.lane_valid[i], bus.sat_flag[i]} = head[i];
  end
endmodule
